uart_tx: RTL and testbench

// - FSM-based UART transmitter; serialises bytes as 8N1, or 8E1 when parity is enabled.
// - Bit period is set at runtime by clk_per_bit. Data is sent LSB first.
// - Line format is the exact inverse of uart_rx, so the two blocks loop back directly.
// - Sits between the host byte interface and the serial line.

---
 rtl/uart_tx.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 or 8E1 (even parity), LSB first, runtime bit period.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry byte FIFO in front of the FSM.
module uart_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic        parity_en,
    input  logic [12:0] clk_per_bit,
    output logic        tx,
    output logic        tx_busy,
    output logic        tx_done
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      state;
    logic [7:0]  data_q;
    logic        par_q;
    logic [12:0] last_q;
    logic [12:0] bit_cnt;
    logic [2:0]  idx;
    logic        bit_end;
    logic [12:0] cpb_last;
    logic        pop;
    logic [7:0]  src_data;

    // Period is stored as N-1 so a zero request behaves like one clock per bit.
    assign cpb_last = (clk_per_bit == 13'd0) ? 13'd0 : clk_per_bit - 13'd1;
    assign bit_end  = (bit_cnt == last_q);

`ifdef UART_TX_FIFO_EN
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, full, empty, want;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign tx_ready = !full;
    assign push     = tx_valid && !full;
    assign want     = (state == IDLE) || (state == STOP && bit_end);
    assign pop      = want && !empty;
    assign src_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
`else
    logic ready_q;

    assign tx_ready = ready_q;
    assign pop      = (state == IDLE) && tx_valid && ready_q;
    assign src_data = tx_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
            bit_cnt <= '0;
            idx     <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            last_q  <= '0;
`ifndef UART_TX_FIFO_EN
            ready_q <= 1'b1;
`endif
        end else begin
            tx_done <= 1'b0;
            // Frame settings are latched only when a byte enters the FSM.
            if (pop) begin
                data_q <= src_data;
                par_q  <= parity_en;
                last_q <= cpb_last;
            end
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        state   <= START;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                        bit_cnt <= '0;
                        idx     <= '0;
`ifndef UART_TX_FIFO_EN
                        ready_q <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= DATA;
                        tx      <= data_q[0];
                    end else begin
                        bit_cnt <= bit_cnt + 13'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (idx == 3'd7) begin
                            if (par_q) begin
                                state <= PARITY;
                                tx    <= ^data_q;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            idx <= idx + 3'd1;
                            tx  <= data_q[idx + 3'd1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 13'd1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= STOP;
                        tx      <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 13'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        tx_done <= 1'b1;
                        // A queued byte chains straight into the next start bit.
                        if (pop) begin
                            state <= START;
                            tx    <= 1'b0;
                            idx   <= '0;
                        end else begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
`ifndef UART_TX_FIFO_EN
                            ready_q <= 1'b1;
`endif
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 13'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: exact line waveform checks plus a mid-bit sampling receiver.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        parity_en;
    logic [12:0] clk_per_bit;
    logic        tx;
    logic        tx_busy;
    logic        tx_done;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .parity_en(parity_en), .clk_per_bit(clk_per_bit),
        .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Returns at the negedge right after the accepting posedge.
    task automatic send(input logic [7:0] b, input logic p, input logic [12:0] n);
        int t = 0;
        @(negedge clk);
        while (!tx_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready", {31'd0, tx_ready}, 32'd1);
        tx_data = b; parity_en = p; clk_per_bit = n; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Checks every clock of a frame starting now (first start-bit cycle).
    task automatic check_frame(input logic [7:0] b, input logic p, input int n, input logic scramble);
        logic [10:0] bits;
        int nb;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = b;
        if (p) bits[9] = ^b;
        nb = p ? 11 : 10;
        for (int c = 0; c < nb * n; c++) begin
            chk("frame_tx", {31'd0, tx}, {31'd0, bits[c / n]});
            chk("frame_busy", {31'd0, tx_busy}, 32'd1);
            chk("frame_done", {31'd0, tx_done}, 32'd0);
`ifndef UART_TX_FIFO_EN
            chk("frame_ready", {31'd0, tx_ready}, 32'd0);
`endif
            if (scramble && c == 3 * n) begin
                tx_data = ~b; parity_en = ~p; clk_per_bit = 13'd3; tx_valid = 1'b1;
            end
            if (scramble && c == 4 * n) tx_valid = 1'b0;
            @(negedge clk);
        end
        chk("end_done", {31'd0, tx_done}, 32'd1);
        chk("end_busy", {31'd0, tx_busy}, 32'd0);
        chk("end_tx", {31'd0, tx}, 32'd1);
        chk("end_ready", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        chk("done_1cyc", {31'd0, tx_done}, 32'd0);
    endtask

    // Mid-bit sampling receiver, the way uart_rx would see the line.
    task automatic rx_byte(input int n, input logic p, output logic [7:0] d,
                           output logic perr, output logic ferr, output logic ok);
        logic [10:0] s;
        int nb, t;
        s = '0; t = 0;
        nb = p ? 11 : 10;
        while (tx !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        ok = (tx === 1'b0);
        for (int c = 0; c < nb * n; c++) begin
            if (c % n == n / 2) s[c / n] = tx;
            @(negedge clk);
        end
        d    = s[8:1];
        perr = p ? (s[9] != ^s[8:1]) : 1'b0;
        ferr = (s[nb - 1] != 1'b1) || (s[0] != 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        logic perr, ferr, ok;
        logic [7:0] lb [4];
        lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h55; lb[3] = 8'h80;

        rst_n = 1'b0; tx_data = '0; tx_valid = 1'b0; parity_en = 1'b0; clk_per_bit = 13'd16;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rst_tx", {31'd0, tx}, 32'd1);
            chk("rst_ready", {31'd0, tx_ready}, 32'd1);
            chk("rst_busy", {31'd0, tx_busy}, 32'd0);
            chk("rst_done", {31'd0, tx_done}, 32'd0);
        end

`ifndef UART_TX_FIFO_EN
        // 0xA5 8N1: start, 1,0,1,0,0,1,0,1, stop; done 160 clks after start edge.
        send(8'hA5, 1'b0, 13'd16);
        check_frame(8'hA5, 1'b0, 16, 1'b0);
        // 0xA5 8E1: four ones, parity bit 0, 176-clk frame; inputs scrambled mid-frame.
        send(8'hA5, 1'b1, 13'd16);
        check_frame(8'hA5, 1'b1, 16, 1'b1);
        // 0x07: three ones, parity bit 1.
        send(8'h07, 1'b1, 13'd16);
        check_frame(8'h07, 1'b1, 16, 1'b0);
        // clk_per_bit=0 behaves as one clock per bit.
        send(8'h6B, 1'b0, 13'd0);
        check_frame(8'h6B, 1'b0, 1, 1'b0);

        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) begin
                send(lb[i], p[0], 13'd10);
                rx_byte(10, p[0], d, perr, ferr, ok);
                chk("lb_valid", {31'd0, ok}, 32'd1);
                chk("lb_data", {24'd0, d}, {24'd0, lb[i]});
                chk("lb_perr", {31'd0, perr}, 32'd0);
                chk("lb_ferr", {31'd0, ferr}, 32'd0);
            end
        end

        // Async reset mid-DATA of 0x3C, then 0x81 must go out intact.
        send(8'h3C, 1'b0, 13'd16);
        repeat (40) @(negedge clk);
        chk("pre_rst_busy", {31'd0, tx_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_busy", {31'd0, tx_busy}, 32'd0);
        chk("midrst_ready", {31'd0, tx_ready}, 32'd1);
        chk("midrst_done", {31'd0, tx_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(8'h81, 1'b0, 13'd16);
        check_frame(8'h81, 1'b0, 16, 1'b0);
`else
        begin
            logic [7:0] fv [5];
            fv[0] = 8'h11; fv[1] = 8'hA5; fv[2] = 8'h3C; fv[3] = 8'hF0; fv[4] = 8'h81;
            fork
                begin
                    int i, t;
                    logic r;
                    i = 0; t = 0;
                    @(negedge clk);
                    tx_valid = 1'b1; tx_data = fv[0]; parity_en = 1'b0; clk_per_bit = 13'd10;
                    while (i < 5 && t < 200) begin
                        r = tx_ready;
                        @(negedge clk);
                        t++;
                        if (r) begin
                            i++;
                            if (i < 5) tx_data = fv[i];
                        end
                    end
                    tx_valid = 1'b0;
                    chk("push_cycles", t, 32'd5);
                    // First byte is already in the FSM, the other four fill the FIFO.
                    chk("full_ready", {31'd0, tx_ready}, 32'd0);
                end
                begin
                    logic [10:0] s;
                    int t;
                    t = 0;
                    while (tx !== 1'b0 && t < 50) begin
                        @(negedge clk);
                        t++;
                    end
                    for (int f = 0; f < 5; f++) begin
                        s = '0;
                        for (int c = 0; c < 100; c++) begin
                            if (c == 0) chk("fifo_start_edge", {31'd0, tx}, 32'd0);
                            if (c == 0 && f > 0) chk("fifo_done_chain", {31'd0, tx_done}, 32'd1);
                            if (c == 99) chk("fifo_stop_last", {31'd0, tx}, 32'd1);
                            chk("fifo_busy", {31'd0, tx_busy}, 32'd1);
                            if (c % 10 == 5) s[c / 10] = tx;
                            @(negedge clk);
                        end
                        chk("fifo_data", {24'd0, s[8:1]}, {24'd0, fv[f]});
                    end
                    chk("fifo_end_done", {31'd0, tx_done}, 32'd1);
                    chk("fifo_end_busy", {31'd0, tx_busy}, 32'd0);
                end
            join
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
